fpu_wb_collector: RTL and testbench

Receiving end of the FPU result path: consumes the `y`/`flagout`/`addout` stream leaving the pipelined fadd/fsub/fmul units and delivers each result to the shared register-file write port. The FPU pipeline cannot stall, so the block issues credits to the dispatcher, buffers results in a small FIFO while the integer unit holds the write port, and keeps a per-register pending scoreboard. It sits between the FPU output tags and the FP register file.

---
 rtl/fpu_wb_collector.sv | 175 +++++++++++++++++
 tb/tb_fpu_wb_collector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_collector.sv
// ---------------------------------------------------------------------------
// fpu_wb_collector
//
// Collects results from the non-stallable FPU pipeline and delivers them to
// the shared FP register-file write port. Credits are issued to the
// dispatcher, so every result that returns is guaranteed a FIFO slot.
// Results wait in a small FIFO while the integer unit holds the write port.
// A per-register pending scoreboard blocks a second issue to a register
// whose result has not been written back yet.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   issue_valid    dispatcher presents one FPU op
//   issue_add      destination register of that op
//   issue_ready    combinational: the op is accepted this cycle
//   fpu_y          result word from the FPU pipeline
//   fpu_flag       result valid strobe from the FPU pipeline
//   fpu_add        destination register of the returning result
//   wb_grant       register-file write port is free this cycle
//   wb_valid       registered: write wb_data to wb_add this cycle
//   wb_add         registered write address
//   wb_data        registered write data
//   busy_mask      registered: bit r set while a result for r is outstanding
//   err            sticky protocol error (spurious result or FIFO overflow)
// ---------------------------------------------------------------------------
module fpu_wb_collector #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_add,
    output logic        issue_ready,
    input  logic [31:0] fpu_y,
    input  logic        fpu_flag,
    input  logic [4:0]  fpu_add,
    input  logic        wb_grant,
    output logic        wb_valid,
    output logic [4:0]  wb_add,
    output logic [31:0] wb_data,
    output logic [31:0] busy_mask,
    output logic        err
);

    // Pointer width and counter width (one bit wider so DEPTH itself fits).
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Result FIFO storage. No reset: validity is tracked by count/pointers,
    // so a reset discards contents simply by clearing those.
    logic [4:0]    add_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;

    logic [CW-1:0] credit_sum;
    logic          issue_fire;
    logic          spurious;
    logic          retire;
    logic          keep_result;
    logic          overflow;
    logic          push;
    logic          pop;

    logic [CW-1:0] count_next;
    logic [CW-1:0] inflight_next;
    logic [31:0]   busy_next;

    // Every issued op owns either an in-flight credit or a FIFO slot, so
    // their sum never exceeds DEPTH and fits in CW bits without wrapping.
    assign credit_sum  = inflight + count;
    assign issue_ready = (credit_sum < DEPTH_C) && !busy_mask[issue_add];
    assign issue_fire  = issue_valid && issue_ready;

    // A result with nothing in flight is a protocol error and is dropped
    // without touching the in-flight count.
    assign spurious    = fpu_flag && (inflight == '0);
    assign retire      = fpu_flag && !spurious;

    // Results for r0 retire a credit but are never written back.
    assign keep_result = retire && (fpu_add != 5'd0);
    assign overflow    = keep_result && (count == DEPTH_C);
    assign push        = keep_result && !overflow;

    // Pop decision uses the registered count, so a result pushed into an
    // empty FIFO cannot be popped on the same edge.
    assign pop         = (count != '0) && wb_grant;

    // In-flight credit bookkeeping: issue adds one, a legal arrival frees one.
    always_comb begin
        inflight_next = inflight;
        case ({issue_fire, retire})
            2'b10:   inflight_next = inflight + CW'(1);
            2'b01:   inflight_next = inflight - CW'(1);
            default: inflight_next = inflight;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Scoreboard update: clear for the popped head first, then set for the
    // new issue, so a coinciding set on the same bit wins.
    always_comb begin
        busy_next = busy_mask;
        if (pop) begin
            busy_next[add_mem[head]] = 1'b0;
        end
        if (issue_fire && (issue_add != 5'd0)) begin
            busy_next[issue_add] = 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            add_mem[tail]  <= fpu_add;
            data_mem[tail] <= fpu_y;
        end
    end

    // Control state, scoreboard and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            inflight  <= '0;
            busy_mask <= '0;
            err       <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count     <= count_next;
            inflight  <= inflight_next;
            busy_mask <= busy_next;
            if (spurious || overflow) begin
                err <= 1'b1;
            end
        end
    end

    // Write-port outputs: one-cycle valid pulse per pop, address/data hold
    // their last value between pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_add   <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= pop;
            if (pop) begin
                wb_add  <= add_mem[head];
                wb_data <= data_mem[head];
            end
        end
    end

endmodule

// File: tb/tb_fpu_wb_collector.sv
// ---------------------------------------------------------------------------
// tb_fpu_wb_collector
//
// Self-checking bench for fpu_wb_collector (DEPTH = 4). Directed sequences
// with hand-computed expectations, followed by a randomised dispatcher /
// fixed-latency-3 FPU run whose writebacks are compared against the issue
// order and the returned data.
// ---------------------------------------------------------------------------
module tb_fpu_wb_collector;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_add;
    logic        issue_ready;
    logic [31:0] fpu_y;
    logic        fpu_flag;
    logic [4:0]  fpu_add;
    logic        wb_grant;
    logic        wb_valid;
    logic [4:0]  wb_add;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;
    logic        err;

    int nChecks = 0;
    int nFail   = 0;

    // Soak model state: FPU pipeline stages and expected writeback queues.
    logic        pv [3];
    logic [4:0]  pa [3];
    logic [31:0] py [3];
    logic [36:0] expQ [$];
    logic [4:0]  orderQ [$];
    logic [36:0] expEntry;
    logic [4:0]  ordEntry;
    logic        sIv;
    logic [4:0]  sIa;
    logic        sGr;
    logic        sAcc;
    int          nWrites = 0;

    fpu_wb_collector #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_add   (issue_add),
        .issue_ready (issue_ready),
        .fpu_y       (fpu_y),
        .fpu_flag    (fpu_flag),
        .fpu_add     (fpu_add),
        .wb_grant    (wb_grant),
        .wb_valid    (wb_valid),
        .wb_add      (wb_add),
        .wb_data     (wb_data),
        .busy_mask   (busy_mask),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive all data inputs for the coming edge, then let combinational
    // outputs settle.
    task automatic applyStimulus(input logic iv, input logic [4:0] ia,
                                 input logic ff, input logic [4:0] fa,
                                 input logic [31:0] fy, input logic gr);
        issue_valid = iv;
        issue_add   = ia;
        fpu_flag    = ff;
        fpu_add     = fa;
        fpu_y       = fy;
        wb_grant    = gr;
        #1;
    endtask

    // Advance one clock edge and sample just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick;
        tick;
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_add", wb_add, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_busy", busy_mask, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_ready", issue_ready, 1);

        // ---------------- single op ----------------
        applyStimulus(1, 5, 0, 0, 0, 1);
        checkOutput("single_ready", issue_ready, 1);
        tick;
        checkOutput("single_busy_set", busy_mask, 32'h0000_0020);
        checkOutput("single_no_wb", wb_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        tick;
        applyStimulus(0, 0, 1, 5, 32'h3F80_0000, 1);
        tick;
        checkOutput("single_busy_arrival", busy_mask, 32'h0000_0020);
        checkOutput("single_wb_early", wb_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("single_wb_valid", wb_valid, 1);
        checkOutput("single_wb_add", wb_add, 5);
        checkOutput("single_wb_data", wb_data, 32'h3F80_0000);
        checkOutput("single_busy_clr", busy_mask, 0);
        tick;
        checkOutput("single_wb_pulse", wb_valid, 0);
        checkOutput("single_wb_add_hold", wb_add, 5);
        checkOutput("single_wb_data_hold", wb_data, 32'h3F80_0000);

        // ---------------- credit limit ----------------
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 5'(i), 0, 0, 0, 0);
            checkOutput($sformatf("credit_ready_%0d", i), issue_ready, 1);
            tick;
        end
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("credit_inflight_full", issue_ready, 0);
        checkOutput("credit_busy", busy_mask, 32'h0000_001E);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 1, 5'(i), 32'h100 + 32'(i), 0);
            tick;
        end
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("credit_fifo_full", issue_ready, 0);
        checkOutput("credit_no_wb", wb_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("credit_wb_valid", wb_valid, 1);
        checkOutput("credit_wb_add_1", wb_add, 1);
        checkOutput("credit_wb_data_1", wb_data, 32'h101);
        checkOutput("credit_busy_after", busy_mask, 32'h0000_001C);
        applyStimulus(1, 5, 0, 0, 0, 0);
        checkOutput("credit_ready_again", issue_ready, 1);
        checkOutput("credit_err", err, 0);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            tick;
            checkOutput($sformatf("credit_drain_add_%0d", i), wb_add, 32'(i));
            checkOutput($sformatf("credit_drain_data_%0d", i), wb_data,
                        32'h100 + 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick;
        checkOutput("credit_idle_wb", wb_valid, 0);
        checkOutput("credit_idle_busy", busy_mask, 0);

        // ---------------- busy hazard ----------------
        applyStimulus(1, 7, 0, 0, 0, 0);
        tick;
        checkOutput("hazard_busy7", busy_mask, 32'h0000_0080);
        applyStimulus(1, 7, 0, 0, 0, 0);
        checkOutput("hazard_block7", issue_ready, 0);
        tick;
        applyStimulus(1, 8, 0, 0, 0, 0);
        checkOutput("hazard_accept8", issue_ready, 1);
        tick;
        checkOutput("hazard_busy78", busy_mask, 32'h0000_0180);
        applyStimulus(0, 0, 1, 7, 32'h77, 0);
        tick;
        applyStimulus(0, 0, 1, 8, 32'h88, 0);
        tick;
        applyStimulus(1, 7, 0, 0, 0, 1);
        checkOutput("hazard_block7_late", issue_ready, 0);
        tick;
        checkOutput("hazard_wb7_valid", wb_valid, 1);
        checkOutput("hazard_wb7_add", wb_add, 7);
        checkOutput("hazard_wb7_data", wb_data, 32'h77);
        checkOutput("hazard_busy8", busy_mask, 32'h0000_0100);
        applyStimulus(1, 7, 0, 0, 0, 1);
        checkOutput("hazard_ready7_after_wb", issue_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("hazard_wb8_add", wb_add, 8);
        checkOutput("hazard_wb8_data", wb_data, 32'h88);
        checkOutput("hazard_busy_clear", busy_mask, 0);
        tick;
        checkOutput("hazard_idle", wb_valid, 0);

        // ---------------- r0 drop ----------------
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("r0_ready", issue_ready, 1);
        tick;
        checkOutput("r0_not_busy", busy_mask, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        tick;
        applyStimulus(0, 0, 1, 0, 32'hDEAD_BEEF, 1);
        tick;
        checkOutput("r0_busy_after", busy_mask, 0);
        checkOutput("r0_err", err, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("r0_no_wb", wb_valid, 0);

        // ---------------- spurious result (also proves inflight == 0) ----
        applyStimulus(0, 0, 1, 3, 32'h1234, 1);
        tick;
        checkOutput("spur_err", err, 1);
        checkOutput("spur_busy", busy_mask, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("spur_no_wb", wb_valid, 0);
        tick;
        tick;
        checkOutput("spur_err_sticky", err, 1);

        // ---------------- reset with queued results ----------------
        applyStimulus(1, 1, 0, 0, 0, 0);
        tick;
        applyStimulus(1, 2, 0, 0, 0, 0);
        tick;
        applyStimulus(0, 0, 1, 1, 32'hAAAA, 0);
        tick;
        applyStimulus(0, 0, 1, 2, 32'hBBBB, 0);
        tick;
        checkOutput("queued_busy", busy_mask, 32'h0000_0006);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("midrst_wb_valid", wb_valid, 0);
        checkOutput("midrst_wb_add", wb_add, 0);
        checkOutput("midrst_wb_data", wb_data, 0);
        checkOutput("midrst_busy", busy_mask, 0);
        checkOutput("midrst_err", err, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 1);
        tick;
        checkOutput("midrst_no_stale_wb", wb_valid, 0);
        tick;
        checkOutput("midrst_no_stale_wb2", wb_valid, 0);

        // ---------------- random soak ----------------
        for (int s = 0; s < 3; s++) begin
            pv[s] = 1'b0;
            pa[s] = '0;
            py[s] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            sIv = (cyc < 360) ? 1'($urandom_range(0, 1)) : 1'b0;
            sIa = 5'($urandom_range(0, 31));
            sGr = (cyc < 360) ? ($urandom_range(0, 3) != 0) : 1'b1;
            applyStimulus(sIv, sIa, pv[2], pa[2], py[2], sGr);
            sAcc = sIv && issue_ready;
            if (pv[2] && (pa[2] != 5'd0)) begin
                expQ.push_back({pa[2], py[2]});
            end
            if (sAcc && (sIa != 5'd0)) begin
                orderQ.push_back(sIa);
            end
            tick;
            if (wb_valid) begin
                nWrites++;
                checkOutput("soak_wb_expected", 32'(wb_valid),
                            32'(expQ.size() != 0 && orderQ.size() != 0));
                if (expQ.size() != 0 && orderQ.size() != 0) begin
                    expEntry = expQ.pop_front();
                    ordEntry = orderQ.pop_front();
                    checkOutput("soak_wb_add", wb_add, expEntry[36:32]);
                    checkOutput("soak_wb_data", wb_data, expEntry[31:0]);
                    checkOutput("soak_issue_order", wb_add, ordEntry);
                end
            end
            pv[2] = pv[1];
            pa[2] = pa[1];
            py[2] = py[1];
            pv[1] = pv[0];
            pa[1] = pa[0];
            py[1] = py[0];
            pv[0] = sAcc;
            pa[0] = sIa;
            py[0] = $urandom;
        end
        checkOutput("soak_pending_results", 32'(expQ.size()), 0);
        checkOutput("soak_pending_issues", 32'(orderQ.size()), 0);
        checkOutput("soak_some_writes", 32'(nWrites > 20), 1);
        checkOutput("soak_err", err, 0);
        checkOutput("soak_busy_idle", busy_mask, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
